// File: rtl/display_scan_mux_if.sv
// Digit bus from the stopwatch counter and the multiplexed display pins.
// The counter side is master; the scan mux is slave.
interface display_scan_mux_if;
  logic [3:0] bcd_h;
  logic [3:0] bcd_min_1;
  logic [3:0] bcd_min_0;
  logic [3:0] bcd_s_1;
  logic [3:0] bcd_s_0;
  logic [3:0] bcd_ms_2;
  logic [3:0] bcd_ms_1;
  logic [3:0] bcd_ms_0;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;
  logic       frame_start;

  modport master (
    output bcd_h,
    output bcd_min_1,
    output bcd_min_0,
    output bcd_s_1,
    output bcd_s_0,
    output bcd_ms_2,
    output bcd_ms_1,
    output bcd_ms_0,
    input  seg,
    input  dp,
    input  an,
    input  frame_start
  );

  modport slave (
    input  bcd_h,
    input  bcd_min_1,
    input  bcd_min_0,
    input  bcd_s_1,
    input  bcd_s_0,
    input  bcd_ms_2,
    input  bcd_ms_1,
    input  bcd_ms_0,
    output seg,
    output dp,
    output an,
    output frame_start
  );
endinterface

// File: rtl/display_scan_mux.sv
// 8-digit 7-segment scan multiplexer with per-frame snapshot, hold,
// inter-digit blanking and leading-zero blanking of the hours digit.
module display_scan_mux #(
  parameter int unsigned DWELL_CYC  = 1,
  parameter int unsigned BLANK_CYC  = 1,
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter bit          LZ_BLANK   = 1'b1
) (
  input  logic              NEclk,
  input  logic              Reset,
  input  logic              Hold,
  display_scan_mux_if.slave bus
);

  localparam int unsigned MAXC =
    (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DWELL_LAST =
    CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST =
    CW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam state_e ENTRY =
    (BLANK_CYC == 0) ? SHOW : BLANK;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0][3:0]   snap_q, snap_d;
  logic              boot_q, boot_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [7:0]        an_q, an_d;
  logic              fs_q, fs_d;

  logic [7:0][3:0]   live;
  logic              wrap;
  logic [3:0]        digit;
  logic              dark;

  function automatic logic [6:0] enc(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign live = {
    bus.bcd_h,
    bus.bcd_min_1,
    bus.bcd_min_0,
    bus.bcd_s_1,
    bus.bcd_s_0,
    bus.bcd_ms_2,
    bus.bcd_ms_1,
    bus.bcd_ms_0
  };

  always_ff @(negedge NEclk) begin
    if (Reset) begin
      state_q <= ENTRY;
      idx_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      boot_q  <= 1'b1;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      an_q    <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      boot_q  <= boot_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      fs_q    <= fs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    boot_d  = 1'b0;
    wrap    = 1'b0;
    fs_d    = 1'b0;
    seg_d   = '0;
    dp_d    = 1'b0;
    an_d    = '0;
    digit   = '0;
    dark    = 1'b0;

    // First edge after reset release re-enters digit 0 as a boundary
    if (boot_q) begin
      state_d = ENTRY;
      idx_d   = '0;
      cnt_d   = '0;
      wrap    = 1'b1;
    end else begin
      unique case (state_q)
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ENTRY;
            idx_d   = idx_q + 3'd1;
            cnt_d   = '0;
            wrap    = (idx_q == 3'd7);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ENTRY;
        end
      endcase
    end

    if (wrap) begin
      fs_d = 1'b1;
      if (!Hold) begin
        snap_d = live;
      end
    end

    // Outputs follow the state being entered, using the fresh snapshot
    digit = snap_d[idx_d];
    dark  = LZ_BLANK && (idx_d == 3'd7) &&
            (digit == 4'd0);

    if (state_d == SHOW && !dark) begin
      an_d  = 8'd1 << idx_d;
      seg_d = enc(digit);
      unique case (1'b1)
        (idx_d == 3'd3): dp_d = 1'b1;
        (idx_d == 3'd5): dp_d = 1'b1;
        (idx_d == 3'd7): dp_d = 1'b1;
        default:         dp_d = 1'b0;
      endcase
    end
  end

  assign bus.seg         = seg_q ^ {7{ACTIVE_LOW}};
  assign bus.dp          = dp_q ^ ACTIVE_LOW;
  assign bus.an          = an_q ^ {8{ACTIVE_LOW}};
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux: active-high and active-low
// instances driven in parallel against a frame-position reference model.
module tb_display_scan_mux;

  logic NEclk = 1'b0;
  logic Reset = 1'b1;
  logic Hold  = 1'b0;
  logic [3:0] dg [8];

  always #5 NEclk = ~NEclk;

  display_scan_mux_if ifa ();
  display_scan_mux_if ifb ();

  assign ifa.bcd_ms_0  = dg[0];
  assign ifa.bcd_ms_1  = dg[1];
  assign ifa.bcd_ms_2  = dg[2];
  assign ifa.bcd_s_0   = dg[3];
  assign ifa.bcd_s_1   = dg[4];
  assign ifa.bcd_min_0 = dg[5];
  assign ifa.bcd_min_1 = dg[6];
  assign ifa.bcd_h     = dg[7];

  assign ifb.bcd_ms_0  = dg[0];
  assign ifb.bcd_ms_1  = dg[1];
  assign ifb.bcd_ms_2  = dg[2];
  assign ifb.bcd_s_0   = dg[3];
  assign ifb.bcd_s_1   = dg[4];
  assign ifb.bcd_min_0 = dg[5];
  assign ifb.bcd_min_1 = dg[6];
  assign ifb.bcd_h     = dg[7];

  display_scan_mux #(
    .DWELL_CYC (1),
    .BLANK_CYC (1),
    .ACTIVE_LOW(1'b0),
    .LZ_BLANK  (1'b1)
  ) dut_a (
    .NEclk(NEclk),
    .Reset(Reset),
    .Hold (Hold),
    .bus  (ifa.slave)
  );

  display_scan_mux #(
    .DWELL_CYC (1),
    .BLANK_CYC (1),
    .ACTIVE_LOW(1'b1),
    .LZ_BLANK  (1'b1)
  ) dut_b (
    .NEclk(NEclk),
    .Reset(Reset),
    .Hold (Hold),
    .bus  (ifb.slave)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  localparam int FL = 16;

  logic [6:0] seg_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  // Reference: position within a 16-cycle frame decides everything
  initial begin : model
    bit         boot;
    int         t;
    int         di;
    logic [3:0] snap [8];
    exp_t       e;
    boot = 1'b1;
    t    = 0;
    for (int i = 0; i < 8; i++) snap[i] = 4'd0;
    forever begin
      @(negedge NEclk);
      e = '0;
      if (Reset) begin
        boot = 1'b1;
        for (int i = 0; i < 8; i++) snap[i] = 4'd0;
      end else begin
        t    = boot ? 0 : (t + 1) % FL;
        boot = 1'b0;
        if (t == 0) begin
          e.fs = 1'b1;
          if (!Hold)
            for (int i = 0; i < 8; i++) snap[i] = dg[i];
        end
        di = t / 2;
        if ((t % 2) == 1 && !(di == 7 && snap[7] == 4'd0)) begin
          e.an  = 8'(1 << di);
          e.seg = seg_tbl[snap[di]];
          e.dp  = (di == 3 || di == 5 || di == 7);
        end
      end
      q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    exp_t ga;
    exp_t gb;
    exp_t xb;
    @(negedge NEclk);
    forever begin
      @(posedge NEclk);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e  = q.pop_front();
        ga = {ifa.seg, ifa.dp, ifa.an, ifa.frame_start};
        gb = {ifb.seg, ifb.dp, ifb.an, ifb.frame_start};
        xb = {~e.seg, ~e.dp, ~e.an, e.fs};
        checks++;
        if (ga !== e) begin
          errors++;
          $display("FAIL high_pins t=%0t got seg=%h dp=%b an=%h fs=%b want seg=%h dp=%b an=%h fs=%b",
                   $time, ga.seg, ga.dp, ga.an, ga.fs,
                   e.seg, e.dp, e.an, e.fs);
        end
        checks++;
        if (gb !== xb) begin
          errors++;
          $display("FAIL low_pins t=%0t got seg=%h dp=%b an=%h fs=%b want seg=%h dp=%b an=%h fs=%b",
                   $time, gb.seg, gb.dp, gb.an, gb.fs,
                   xb.seg, xb.dp, xb.an, xb.fs);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge NEclk);
      #2;
    end
  endtask

  task automatic set_time(
    input logic [3:0] h,
    input logic [3:0] m1, input logic [3:0] m0,
    input logic [3:0] s1, input logic [3:0] s0,
    input logic [3:0] c2, input logic [3:0] c1,
    input logic [3:0] c0
  );
    dg[7] = h;
    dg[6] = m1;
    dg[5] = m0;
    dg[4] = s1;
    dg[3] = s0;
    dg[2] = c2;
    dg[1] = c1;
    dg[0] = c0;
  endtask

  task automatic rand_digits();
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0)
        dg[i] = 4'($urandom_range(10, 15));
      else
        dg[i] = 4'($urandom_range(0, 9));
    end
  endtask

  initial begin : driver
    Reset = 1'b1;
    Hold  = 1'b0;
    set_time(1, 2, 3, 4, 5, 6, 7, 8);
    tick(3);
    Reset = 1'b0;
    tick(32);
    dg[7] = 4'd0;
    tick(16);
    dg[7] = 4'd1;
    dg[3] = 4'hC;
    tick(16);
    tick(5);
    rand_digits();
    tick(20);
    Hold = 1'b1;
    tick(3);
    rand_digits();
    tick(40);
    Hold = 1'b0;
    tick(20);
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(10);
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    Hold  = 1'b1;
    tick(20);
    Hold = 1'b0;
    tick(20);
    repeat (800) begin
      if ($urandom_range(0, 15) == 0) rand_digits();
      if ($urandom_range(0, 31) == 0) Hold = ~Hold;
      Reset = ($urandom_range(0, 149) == 0);
      tick(1);
    end
    Reset = 1'b0;
    Hold  = 1'b0;
    tick(20);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
